fp_multiply_pipe: RTL



---
 rtl/fp_pkg.sv | 37 +++
 rtl/fp_mul_round.sv | 93 +++++++++
 rtl/fp_multiply_pipe.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
//
// Contents:
//   FLG_*         bit positions inside the 4-bit exception flag vector
//   fp_class_e    operand classification produced in S1
//   fp_special_e  special-case result decided in S1 and carried to S3
//   exp_bias()    exponent bias for a given exponent width
package fp_pkg;

   localparam int FLG_INVALID   = 3;
   localparam int FLG_OVERFLOW  = 2;
   localparam int FLG_UNDERFLOW = 1;
   localparam int FLG_INEXACT   = 0;

   // Subnormal operands classify as ZERO (denormals-are-zero).
   typedef enum logic [1:0] {
      ZERO = 2'd0,
      NORM = 2'd1,
      INF  = 2'd2,
      NAN  = 2'd3
   } fp_class_e;

   // SP_NONE means the result comes from the rounded mantissa product.
   typedef enum logic [1:0] {
      SP_NONE = 2'd0,
      SP_ZERO = 2'd1,
      SP_INF  = 2'd2,
      SP_QNAN = 2'd3
   } fp_special_e;

   function automatic int exp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_mul_round.sv
// S3 of the multiplier: normalise, round-to-nearest-even, detect exceptions, pack.
// Latency: purely combinational; the caller registers z/flags.
// Backpressure: none here, the caller's stage enable governs when results are captured.
//
// Ports:
//   sign     result sign (XOR of operand signs)
//   exp_sum  ea+eb-bias, signed, EXP_W+2 bits
//   prod     (MAN_W+1)x(MAN_W+1) mantissa product, hidden bits included
//   special  special-case result chosen in S1
//   invalid  invalid-operation flag chosen in S1 (only meaningful with SP_QNAN)
//   z        packed result {sign, exp, frac}
//   flags    {invalid, overflow, underflow, inexact}
module fp_mul_round
   import fp_pkg::*;
#(
   parameter int EXP_W = 11,
   parameter int MAN_W = 52
) (
   input  logic                    sign,
   input  logic signed [EXP_W+1:0] exp_sum,
   input  logic [2*MAN_W+1:0]      prod,
   input  fp_special_e             special,
   input  logic                    invalid,
   output logic [EXP_W+MAN_W:0]    z,
   output logic [3:0]              flags
);

   localparam int PW = 2 * (MAN_W + 1);
   localparam int XW = EXP_W + 2;
   localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;

   // Product of two [1,2) significands lies in [1,4). norm drops the leading
   // one, so norm holds only the fraction and the bits below it.
   logic [PW-2:0]          norm;
   logic [MAN_W-1:0]       frac_n;
   logic                   lsb;
   logic                   guard;
   logic                   sticky;
   logic                   round_up;
   logic [MAN_W:0]         frac_r;
   logic                   carry;
   logic signed [XW-1:0]   exp_n;
   logic signed [XW-1:0]   exp_f;

   always_comb begin
      norm     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
      frac_n   = norm[PW-2 -: MAN_W];
      lsb      = norm[PW-1-MAN_W];
      guard    = norm[PW-2-MAN_W];
      sticky   = |norm[PW-3-MAN_W:0];
      round_up = guard & (sticky | lsb);

      // The hidden bit is always one, so a carry out of the fraction is the
      // same as a carry out of the full significand. On carry the fraction
      // bits are already zero and the exponent moves up by one.
      frac_r = {1'b0, frac_n} + (MAN_W+1)'(round_up);
      carry  = frac_r[MAN_W];
      exp_n  = exp_sum + XW'(prod[PW-1]);
      exp_f  = exp_n + XW'(carry);

      z     = '0;
      flags = '0;
      case (special)
         SP_QNAN: begin
            z                  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags[FLG_INVALID] = invalid;
         end
         SP_INF: begin
            z = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end
         SP_ZERO: begin
            z = {sign, {(EXP_W+MAN_W){1'b0}}};
         end
         default: begin
            if (exp_f >= EXP_MAX) begin
               z                   = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags[FLG_OVERFLOW] = 1'b1;
               flags[FLG_INEXACT]  = 1'b1;
            end else if (exp_f <= EXP_ZERO) begin
               // No subnormal outputs: anything below the normal range flushes.
               z                    = {sign, {(EXP_W+MAN_W){1'b0}}};
               flags[FLG_UNDERFLOW] = 1'b1;
               flags[FLG_INEXACT]   = 1'b1;
            end else begin
               z                  = {sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
               flags[FLG_INEXACT] = guard | sticky;
            end
         end
      endcase
   end

endmodule

// File: rtl/fp_multiply_pipe.sv
// Fully pipelined IEEE-754-style multiplier with DAZ/FTZ, RNE rounding and tag sideband.
// Latency: 3 cycles (operand accepted at edge N is on out_* after edge N+3).
// Backpressure: global stall, en = !out_valid || out_ready; in_ready = en (combinational from out_ready).
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid/in_ready    operand handshake; in_a/in_b are {sign, exp, frac}
//   in_tag               caller tag, returned unchanged on out_tag
//   out_valid/out_ready  result handshake
//   out_z                packed product
//   out_flags            {invalid, overflow, underflow, inexact}
module fp_multiply_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 11,
   parameter int MAN_W = 52,
   parameter int TAG_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_z,
   output logic [TAG_W-1:0]       out_tag,
   output logic [3:0]             out_flags
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int SW   = MAN_W + 1;
   localparam int PW   = 2 * SW;
   localparam int XW   = EXP_W + 2;
   localparam int BIAS = exp_bias(EXP_W);

   typedef struct packed {
      logic           sign;
      logic [XW-1:0]  exp_sum;   // two's complement
      logic [SW-1:0]  man_a;
      logic [SW-1:0]  man_b;
      fp_special_e    special;
      logic           invalid;
   } s1_t;

   typedef struct packed {
      logic           sign;
      logic [XW-1:0]  exp_sum;
      logic [PW-1:0]  prod;
      fp_special_e    special;
      logic           invalid;
   } s2_t;

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] f);
      if (e == '0)
         return ZERO;
      else if (e == '1)
         return (f == '0) ? INF : NAN;
      else
         return NORM;
   endfunction

   // Global stall: every rank advances together, so bubbles stay in place.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Operand capture rank: ports go straight into flops before any logic.
   logic             s0_vld;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [TAG_W-1:0] s0_tag;

   logic             s1_vld;
   s1_t              s1_d;
   s1_t              s1_q;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_vld;
   s2_t              s2_d;
   s2_t              s2_q;
   logic [TAG_W-1:0] s2_tag;

   logic [W-1:0]     rnd_z;
   logic [3:0]       rnd_flags;

   // ---------------- S1: unpack, classify, sign and exponent sum ----------
   logic [EXP_W-1:0] ea;
   logic [EXP_W-1:0] eb;
   logic [MAN_W-1:0] fa;
   logic [MAN_W-1:0] fb;
   fp_class_e        cls_a;
   fp_class_e        cls_b;

   assign ea    = a_q[MAN_W +: EXP_W];
   assign eb    = b_q[MAN_W +: EXP_W];
   assign fa    = a_q[MAN_W-1:0];
   assign fb    = b_q[MAN_W-1:0];
   assign cls_a = classify(ea, fa);
   assign cls_b = classify(eb, fb);

   always_comb begin
      s1_d         = '0;
      s1_d.sign    = a_q[W-1] ^ b_q[W-1];
      s1_d.exp_sum = XW'({2'b00, ea}) + XW'({2'b00, eb}) - XW'(BIAS);
      s1_d.man_a   = {1'b1, fa};
      s1_d.man_b   = {1'b1, fb};
      s1_d.special = SP_NONE;
      s1_d.invalid = 1'b0;
      // NaN beats everything; Inf*0 is the only invalid operation.
      if (cls_a == NAN || cls_b == NAN) begin
         s1_d.special = SP_QNAN;
      end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
         s1_d.special = SP_QNAN;
         s1_d.invalid = 1'b1;
      end else if (cls_a == INF || cls_b == INF) begin
         s1_d.special = SP_INF;
      end else if (cls_a == ZERO || cls_b == ZERO) begin
         s1_d.special = SP_ZERO;
      end
   end

   // ---------------- S2: mantissa product --------------------------------
   always_comb begin
      s2_d         = '0;
      s2_d.sign    = s1_q.sign;
      s2_d.exp_sum = s1_q.exp_sum;
      s2_d.prod    = {{SW{1'b0}}, s1_q.man_a} * {{SW{1'b0}}, s1_q.man_b};
      s2_d.special = s1_q.special;
      s2_d.invalid = s1_q.invalid;
   end

   // ---------------- S3: normalise / round / pack -------------------------
   fp_mul_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .sign    (s2_q.sign),
      .exp_sum ($signed(s2_q.exp_sum)),
      .prod    (s2_q.prod),
      .special (s2_q.special),
      .invalid (s2_q.invalid),
      .z       (rnd_z),
      .flags   (rnd_flags)
   );

   // ---------------- Pipeline registers ------------------------------------
   // Reset clears every rank, so in-flight operations never reach the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0_vld    <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         s0_tag    <= '0;
         s1_vld    <= 1'b0;
         s1_q      <= '0;
         s1_tag    <= '0;
         s2_vld    <= 1'b0;
         s2_q      <= '0;
         s2_tag    <= '0;
         out_valid <= 1'b0;
         out_z     <= '0;
         out_tag   <= '0;
         out_flags <= '0;
      end else if (en) begin
         s0_vld    <= in_valid;
         a_q       <= in_a;
         b_q       <= in_b;
         s0_tag    <= in_tag;
         s1_vld    <= s0_vld;
         s1_q      <= s1_d;
         s1_tag    <= s0_tag;
         s2_vld    <= s1_vld;
         s2_q      <= s2_d;
         s2_tag    <= s1_tag;
         out_valid <= s2_vld;
         out_z     <= rnd_z;
         out_tag   <= s2_tag;
         out_flags <= rnd_flags;
      end
   end

endmodule
